// File: rtl/audio_axis_slave.sv
// -----------------------------------------------------------------------------
// audio_axis_slave
//
// Purpose:
//   Receives stereo audio as an AXI-stream sequence of beats: one left beat
//   (axis_last=0) followed by one right beat (axis_last=1). From each beat it
//   takes the AUDIO_OUT_DW most significant bits of the AUDIO_BIT_RATE-wide
//   MSB-justified field and presents the recovered left/right pair on a
//   valid/ready output handshake. Beats that break the left/right framing are
//   dropped and reported with a one-cycle frame_error pulse.
//
// Parameters:
//   AUDIO_IN_DW    - AXI-stream beat width
//   AUDIO_OUT_DW   - width of each recovered sample
//   AUDIO_BIT_RATE - width of the MSB-justified sample field inside a beat
//
// Ports:
//   clk           in   single clock, rising edge
//   reset         in   synchronous active-high reset
//   axis_data     in   [AUDIO_IN_DW-1:0] stream beat payload
//   axis_valid    in   beat valid
//   axis_last     in   set on the right-channel beat closing a frame
//   axis_ready    out  beat accept (combinational)
//   left_output   out  [AUDIO_OUT_DW-1:0] registered left sample
//   right_output  out  [AUDIO_OUT_DW-1:0] registered right sample
//   sample_valid  out  output pair is held and not yet consumed
//   sample_ready  in   consumer accepts the output pair
//   frame_error   out  one-cycle pulse per framing violation
//   error_count   out  [7:0] saturating count of framing violations
//
// Build option:
//   AUDIO_AXIS_ERR_COUNT_EN - when defined, error_count counts frame_error
//   pulses and saturates at 8'hFF; when undefined, error_count is tied to
//   8'h00 and no counter is built. frame_error is identical in both builds.
// -----------------------------------------------------------------------------
module audio_axis_slave #(
  parameter int AUDIO_IN_DW    = 32,
  parameter int AUDIO_OUT_DW   = 12,
  parameter int AUDIO_BIT_RATE = 24
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AUDIO_IN_DW-1:0]  axis_data,
  input  logic                    axis_valid,
  input  logic                    axis_last,
  output logic                    axis_ready,
  output logic [AUDIO_OUT_DW-1:0] left_output,
  output logic [AUDIO_OUT_DW-1:0] right_output,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    frame_error,
  output logic [7:0]              error_count
);

  typedef enum logic {
    S_LEFT  = 1'b0,  // waiting for the left beat of a frame
    S_RIGHT = 1'b1   // left sample held, waiting for the closing right beat
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;

  logic [AUDIO_OUT_DW-1:0] r_left_hold;
  logic [AUDIO_OUT_DW-1:0] r_left_out;
  logic [AUDIO_OUT_DW-1:0] r_right_out;
  logic                    r_sample_valid;
  logic                    r_frame_error;

  logic                    w_accept;
  logic [AUDIO_OUT_DW-1:0] w_field;
  logic                    w_capture_left;
  logic                    w_load_pair;
  logic                    w_violation;

  // Only the sample field of a beat carries information; the reduction keeps
  // the remaining payload bits formally connected without giving them meaning.
  logic                    w_unused_axis_bits;
  assign w_unused_axis_bits = ^axis_data;

  // Sample field: top AUDIO_OUT_DW bits of the MSB-justified audio word.
  assign w_field = axis_data[AUDIO_BIT_RATE-1 -: AUDIO_OUT_DW];

  // Left beats are always accepted because they only touch left_hold. The
  // right beat overwrites the output pair, so it waits until the current
  // pair is gone or is being consumed on this same edge.
  assign axis_ready = (r_state == S_LEFT) ? 1'b1
                                          : (!r_sample_valid || sample_ready);

  assign w_accept = axis_valid && axis_ready;

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: all clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LEFT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and per-beat decisions
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    w_next_state   = r_state;
    w_capture_left = 1'b0;
    w_load_pair    = 1'b0;
    w_violation    = 1'b0;

    case (r_state)
      S_LEFT: begin
        if (w_accept) begin
          if (axis_last) begin
            // A frame cannot close on its first beat: drop it, stay put.
            w_violation = 1'b1;
          end else begin
            w_capture_left = 1'b1;
            w_next_state   = S_RIGHT;
          end
        end
      end

      S_RIGHT: begin
        if (w_accept) begin
          if (axis_last) begin
            w_load_pair = 1'b1;
          end else begin
            // Frame ran past two beats: drop the held left sample and this
            // beat, and resynchronise on the next beat as a left beat.
            w_violation = 1'b1;
          end
          w_next_state = S_LEFT;
        end
      end

      default: begin
        w_next_state = S_LEFT;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sample capture and output pair
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_left_hold    <= '0;
      r_left_out     <= '0;
      r_right_out    <= '0;
      r_sample_valid <= 1'b0;
    end else begin
      if (w_capture_left) begin
        r_left_hold <= w_field;
      end

      // The pair only changes when a full frame completes, so it stays
      // stable for as long as the consumer holds sample_ready low.
      if (w_load_pair) begin
        r_left_out  <= r_left_hold;
        r_right_out <= w_field;
      end

      // A new pair arriving on the consume edge keeps valid high.
      if (w_load_pair) begin
        r_sample_valid <= 1'b1;
      end else if (r_sample_valid && sample_ready) begin
        r_sample_valid <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Framing error pulse
  // ---------------------------------------------------------------------------
  // Registered directly from the violation strobe: high for exactly one cycle
  // per violating beat, and high on consecutive cycles for back-to-back ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_error <= 1'b0;
    end else begin
      r_frame_error <= w_violation;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional saturating error counter
  // ---------------------------------------------------------------------------
`ifdef AUDIO_AXIS_ERR_COUNT_EN
  logic [7:0] r_error_count;

  // Counts on the same edge that raises frame_error, so the count and the
  // pulse become visible together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_error_count <= 8'h00;
    end else if (w_violation && (r_error_count != 8'hFF)) begin
      r_error_count <= r_error_count + 8'd1;
    end
  end

  assign error_count = r_error_count;
`else
  assign error_count = 8'h00;
`endif

  assign left_output  = r_left_out;
  assign right_output = r_right_out;
  assign sample_valid = r_sample_valid;
  assign frame_error  = r_frame_error;

endmodule

// File: tb/tb_audio_axis_slave.sv
// -----------------------------------------------------------------------------
// tb_audio_axis_slave
//
// Directed testbench for audio_axis_slave with default parameters
// (32-bit beats, 12-bit samples taken from bits [23:12]). Inputs are driven
// 1 ns after the rising edge; outputs are compared at the same point, away
// from the active edge. Expected values are hand-computed constants plus a
// violation counter used to predict error_count in either build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_audio_axis_slave;

  logic        clk;
  logic        reset;
  logic [31:0] axis_data;
  logic        axis_valid;
  logic        axis_last;
  logic        axis_ready;
  logic [11:0] left_output;
  logic [11:0] right_output;
  logic        sample_valid;
  logic        sample_ready;
  logic        frame_error;
  logic [7:0]  error_count;

  int checks = 0;
  int errors = 0;
  int n_viol = 0;   // violations since the last reset

  audio_axis_slave #(
    .AUDIO_IN_DW    (32),
    .AUDIO_OUT_DW   (12),
    .AUDIO_BIT_RATE (24)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .axis_data    (axis_data),
    .axis_valid   (axis_valid),
    .axis_last    (axis_last),
    .axis_ready   (axis_ready),
    .left_output  (left_output),
    .right_output (right_output),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .frame_error  (frame_error),
    .error_count  (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected error_count after n violations in the current build.
  function automatic logic [7:0] ec_exp(input int n);
`ifdef AUDIO_AXIS_ERR_COUNT_EN
    return (n > 255) ? 8'hFF : n[7:0];
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and wait (bounded) until it is accepted.
  task automatic beat(input string tag, input logic [31:0] d, input logic l);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    axis_data  = d;
    axis_last  = l;
    axis_valid = 1'b1;
    while (!acc && n < 20) begin
      #1;
      acc = axis_ready;
      @(posedge clk);
      #1;
      n++;
    end
    axis_valid = 1'b0;
    axis_last  = 1'b0;
    check({tag, "_accepted"}, {31'd0, acc}, 32'd1);
  endtask

  initial begin
    reset        = 1'b1;
    axis_data    = '0;
    axis_valid   = 1'b0;
    axis_last    = 1'b0;
    sample_ready = 1'b0;

    // ---- reset state ----------------------------------------------------
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_axis_ready", {31'd0, axis_ready}, 32'd1);
    check("rst_left",       {20'd0, left_output}, 32'h0);
    check("rst_right",      {20'd0, right_output}, 32'h0);
    check("rst_valid",      {31'd0, sample_valid}, 32'd0);
    check("rst_ferr",       {31'd0, frame_error}, 32'd0);
    check("rst_ecount",     {24'd0, error_count}, 32'h0);

    // ---- basic frame, consumer always ready -----------------------------
    sample_ready = 1'b1;
    beat("b1_left", 32'h00ABC000, 1'b0);
    check("b1_no_valid_yet", {31'd0, sample_valid}, 32'd0);
    beat("b1_right", 32'h00123000, 1'b1);
    check("b1_valid", {31'd0, sample_valid}, 32'd1);
    check("b1_left_out",  {20'd0, left_output}, 32'hABC);
    check("b1_right_out", {20'd0, right_output}, 32'h123);
    check("b1_ferr", {31'd0, frame_error}, 32'd0);
    tick();
    check("b1_valid_one_cycle", {31'd0, sample_valid}, 32'd0);

    // ---- backpressure: second right beat stalls -------------------------
    sample_ready = 1'b0;
    beat("bp_left1", 32'h00111000, 1'b0);
    beat("bp_right1", 32'h00222000, 1'b1);
    check("bp_valid1", {31'd0, sample_valid}, 32'd1);
    beat("bp_left2", 32'h00333000, 1'b0);
    axis_data  = 32'h00444000;
    axis_last  = 1'b1;
    axis_valid = 1'b1;
    #1;
    check("bp_stall_ready", {31'd0, axis_ready}, 32'd0);
    tick();
    tick();
    check("bp_stall_ready2", {31'd0, axis_ready}, 32'd0);
    check("bp_hold_left",  {20'd0, left_output}, 32'h111);
    check("bp_hold_right", {20'd0, right_output}, 32'h222);
    check("bp_hold_valid", {31'd0, sample_valid}, 32'd1);
    sample_ready = 1'b1;
    #1;
    check("bp_release_ready", {31'd0, axis_ready}, 32'd1);
    tick();
    axis_valid = 1'b0;
    axis_last  = 1'b0;
    check("bp_valid_kept", {31'd0, sample_valid}, 32'd1);
    check("bp_left2_out",  {20'd0, left_output}, 32'h333);
    check("bp_right2_out", {20'd0, right_output}, 32'h444);
    tick();
    check("bp_consumed", {31'd0, sample_valid}, 32'd0);

    // ---- left beat carrying last: violation -----------------------------
    beat("v1_left_last", 32'h00555000, 1'b1);
    n_viol++;
    check("v1_ferr", {31'd0, frame_error}, 32'd1);
    check("v1_ecount", {24'd0, error_count}, {24'd0, ec_exp(n_viol)});
    check("v1_no_valid", {31'd0, sample_valid}, 32'd0);
    tick();
    check("v1_ferr_single", {31'd0, frame_error}, 32'd0);
    beat("v1_left", 32'h00666000, 1'b0);
    check("v1_left_ferr", {31'd0, frame_error}, 32'd0);
    beat("v1_right", 32'h00777000, 1'b1);
    check("v1_left_out",  {20'd0, left_output}, 32'h666);
    check("v1_right_out", {20'd0, right_output}, 32'h777);
    check("v1_valid", {31'd0, sample_valid}, 32'd1);

    // ---- two left beats in a row: violation in S_RIGHT ------------------
    tick();
    beat("v2_left", 32'h00888000, 1'b0);
    beat("v2_second", 32'h00999000, 1'b0);
    n_viol++;
    check("v2_ferr", {31'd0, frame_error}, 32'd1);
    check("v2_ecount", {24'd0, error_count}, {24'd0, ec_exp(n_viol)});
    check("v2_hold_left",  {20'd0, left_output}, 32'h666);
    check("v2_hold_right", {20'd0, right_output}, 32'h777);
    check("v2_no_valid", {31'd0, sample_valid}, 32'd0);
    beat("v2_next_left", 32'h00AAA000, 1'b0);
    check("v2_next_is_left", {31'd0, frame_error}, 32'd0);
    beat("v2_next_right", 32'h00BBB000, 1'b1);
    check("v2_left_out",  {20'd0, left_output}, 32'hAAA);
    check("v2_right_out", {20'd0, right_output}, 32'hBBB);

    // ---- back-to-back violations ----------------------------------------
    tick();
    axis_data  = 32'h00CCC000;
    axis_last  = 1'b1;
    axis_valid = 1'b1;
    tick();
    n_viol++;
    check("bb_ferr1", {31'd0, frame_error}, 32'd1);
    tick();
    n_viol++;
    axis_valid = 1'b0;
    axis_last  = 1'b0;
    check("bb_ferr2", {31'd0, frame_error}, 32'd1);
    check("bb_ecount", {24'd0, error_count}, {24'd0, ec_exp(n_viol)});
    tick();
    check("bb_ferr_low", {31'd0, frame_error}, 32'd0);

    // ---- reset while a frame is half received ---------------------------
    beat("rs_left", 32'h00CCC000, 1'b0);
    reset      = 1'b1;
    axis_data  = 32'h00DDD000;
    axis_last  = 1'b0;      // would be a violation if reset did not win
    axis_valid = 1'b1;
    tick();
    reset      = 1'b0;
    axis_valid = 1'b0;
    n_viol     = 0;
    #1;
    check("rs_left_out",  {20'd0, left_output}, 32'h0);
    check("rs_right_out", {20'd0, right_output}, 32'h0);
    check("rs_valid", {31'd0, sample_valid}, 32'd0);
    check("rs_ferr",  {31'd0, frame_error}, 32'd0);
    check("rs_ecount", {24'd0, error_count}, 32'h0);
    check("rs_ready", {31'd0, axis_ready}, 32'd1);
    tick();
    check("rs_ferr_after", {31'd0, frame_error}, 32'd0);
    beat("rs_next_left", 32'h00EEE000, 1'b0);
    check("rs_next_is_left", {31'd0, frame_error}, 32'd0);
    beat("rs_next_right", 32'h00FFF000, 1'b1);
    check("rs_left_out2",  {20'd0, left_output}, 32'hEEE);
    check("rs_right_out2", {20'd0, right_output}, 32'hFFF);

    // ---- 300 violations: saturation (or tie-off) ------------------------
    tick();
    axis_data  = 32'h00123000;
    axis_last  = 1'b1;
    axis_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      n_viol++;
      if (n_viol == 1 || n_viol == 254 || n_viol == 255 || n_viol == 256)
        check($sformatf("sat_ecount_%0d", n_viol), {24'd0, error_count},
              {24'd0, ec_exp(n_viol)});
    end
    axis_valid = 1'b0;
    axis_last  = 1'b0;
    check("sat_ferr_last", {31'd0, frame_error}, 32'd1);
    check("sat_ecount_300", {24'd0, error_count}, {24'd0, ec_exp(n_viol)});
    tick();
    check("sat_ferr_done", {31'd0, frame_error}, 32'd0);
    check("sat_ecount_hold", {24'd0, error_count}, {24'd0, ec_exp(n_viol)});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/audio_axis_slave.md
AUDIO_AXIS_SLAVE -- requirements
Module: audio_axis_slave

Interface
REQ-001 SHALL have parameter AUDIO_IN_DW, default 32, the AXI-stream beat width.
REQ-002 SHALL have parameter AUDIO_OUT_DW, default 12, the width of each recovered sample.
REQ-003 SHALL have parameter AUDIO_BIT_RATE, default 24, the sample's MSB-justified field width inside a beat.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port axis_data, input, AUDIO_IN_DW, the stream beat payload.
REQ-007 SHALL have port axis_valid, input, 1, beat valid.
REQ-008 SHALL have port axis_last, input, 1, set on the right-channel beat closing a frame.
REQ-009 SHALL have port axis_ready, output, 1, beat accept.
REQ-010 SHALL have port left_output, output, AUDIO_OUT_DW, the registered left sample.
REQ-011 SHALL have port right_output, output, AUDIO_OUT_DW, the registered right sample.
REQ-012 SHALL have port sample_valid, output, 1, indicating the output pair is held and unconsumed.
REQ-013 SHALL have port sample_ready, input, 1, consumer accept for the output pair.
REQ-014 SHALL have port frame_error, output, 1, a one-cycle pulse per framing violation.
REQ-015 SHALL have port error_count, output, 8, a saturating count of framing violations.

Function
REQ-016 SHALL define a beat as accepted when axis_valid and axis_ready are both high on a rising clk edge.
REQ-017 SHALL implement a two-state FSM: S_LEFT (expect left beat) and S_RIGHT (expect right beat).
REQ-018 SHALL extract each sample as axis_data[AUDIO_BIT_RATE-1 : AUDIO_BIT_RATE-AUDIO_OUT_DW] and ignore all other bits.
REQ-019 SHALL drive axis_ready combinationally: 1 in S_LEFT; in S_RIGHT, (!sample_valid || sample_ready).
REQ-020 SHALL handle an accepted S_LEFT beat with axis_last=0 by capturing the field into an internal left_hold register and moving to S_RIGHT.
REQ-021 SHALL handle an accepted S_LEFT beat with axis_last=1 by discarding it, pulsing frame_error, and staying in S_LEFT.
REQ-022 SHALL handle an accepted S_RIGHT beat with axis_last=1 by loading left_hold into left_output and the field into right_output, setting sample_valid, and moving to S_LEFT.
REQ-023 SHALL handle an accepted S_RIGHT beat with axis_last=0 by discarding left_hold and the beat, pulsing frame_error, moving to S_LEFT, and leaving the outputs unchanged.
REQ-024 SHALL update outputs with a latency of one cycle from the right-beat acceptance edge to sample_valid high.
REQ-025 SHALL clear sample_valid on sample_valid && sample_ready, unless a new pair loads on the same edge, in which case sample_valid stays 1 with the new data.
REQ-026 SHALL hold left_output and right_output stable while sample_valid=1 and sample_ready=0.
REQ-027 SHALL keep frame_error low in every cycle without a violation; back-to-back violations SHALL pulse on consecutive cycles.

Reset
REQ-028 SHALL, on reset, set state=S_LEFT, left_hold=0, left_output=0, right_output=0, sample_valid=0, frame_error=0, and error_count=0.
REQ-029 SHALL give reset priority over every other event; a half-received frame (S_RIGHT) SHALL be dropped with no frame_error pulse.
REQ-030 SHALL hold axis_ready at 1 on the first cycle after reset.

Configuration
REQ-031 SHALL, with AUDIO_AXIS_ERR_COUNT_EN defined, increment error_count by one on each frame_error pulse, saturating at 8'hFF.
REQ-032 SHALL, without AUDIO_AXIS_ERR_COUNT_EN, tie error_count to 8'h00 and keep no counter logic; frame_error SHALL behave identically in both builds.

Verification
REQ-033 SHALL cover: beats 32'h00ABC000 (last=0) then 32'h00123000 (last=1), sample_ready=1 -> one cycle later left_output=12'hABC, right_output=12'h123, sample_valid=1 for one cycle.
REQ-034 SHALL cover: two full frames with sample_ready=0 -> the 2nd right beat sees axis_ready=0 and stalls; outputs hold frame 1; raising sample_ready accepts it and outputs frame 2.
REQ-035 SHALL cover: left beat with last=1 -> frame_error pulses once, state stays S_LEFT, a following valid frame decodes correctly.
REQ-036 SHALL cover: left beat then a second beat with last=0 -> frame_error pulses, outputs unchanged, the next beat is treated as left.
REQ-037 SHALL cover: reset asserted in S_RIGHT -> all outputs 0, no frame_error, the next beat is taken as left.
REQ-038 SHALL cover: 300 violations with AUDIO_AXIS_ERR_COUNT_EN defined -> error_count=8'hFF; without the macro -> error_count=8'h00 throughout.
